keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Synchronous 4x3 keypad matrix scanner for the electronic lock. Drives the keypad column lines one at a time, samples and debounces the row lines, and decodes presses into lock commands: `arm` (#), `unarm` (*), and `openreq` with a 4-digit `keys` code. It is the driving end of the row/column keypad interface. Its command outputs connect directly to the lock controller's `arm`/`unarm`/`openreq`/`keys` inputs.

## Interface
- SCAN_DIV, 1000: clock cycles each column is driven (dwell). Must be ≥ 4.
- DEBOUNCE, 3: consecutive full scans that must agree before a press or release is accepted. Must be ≥ 1.
- TIMEOUT_SCANS, 2000: full scans with no accepted press before a partial entry is discarded. 0 disables the timeout.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- row  in  4  keypad row lines, active-high, asynchronous to clk
- col  out  3  column drive, one-hot, active-high
- key_valid  out  1  one-cycle pulse on every accepted press (digits, # and *)
- key_code  out  4  code of the last accepted press; held between presses
- arm  out  1  one-cycle pulse when # is accepted
- unarm  out  1  one-cycle pulse when * is accepted
- openreq  out  1  one-cycle pulse when the 4th digit is accepted
- keys  out  16  last completed code, first digit in [15:12]; held until the next openreq
- digit_count  out  3  digits entered in the current partial code (0..3)

## Operation
- Row synchronizer: `row` passes through a 2-flop synchronizer. All logic uses only the synchronized value.
- Column sequencer: columns are driven in order col0 → col1 → col2 → col0. Each column is driven for SCAN_DIV cycles.
- Sampling: the synchronized rows are sampled on the last cycle of each dwell. One full scan ends with the col2 sample.
- Per-scan result (evaluated on the cycle after the col2 sample):
  - NONE: no row bit set in any column.
  - SINGLE(r,c): exactly one (row, column) intersection set.
  - MULTI: any other pattern.
- Key encoding, using the decode the lock already uses:
  - r0c0 = # (code 4'hB)
  - r0c2 = * (code 4'hC)
  - r0c1 = digit 0 (code 4'hA)
  - all other keys: code = 1 + 3·(3−r) + (2−c). So r3c2 = 1, r3c1 = 2, r3c0 = 3, r2c2 = 4, …, r1c0 = 9.
- Debounce FSM, states IDLE, PRESS_PEND, HELD, REL_PEND:
  - IDLE:
    - SINGLE(k) → PRESS_PEND with cand = k, cnt = 1.
    - If DEBOUNCE = 1, go straight to accept.
  - PRESS_PEND:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE → accept, go to HELD.
    - SINGLE(other key): restart with the new cand, cnt = 1.
    - NONE or MULTI: → IDLE.
  - HELD:
    - NONE → REL_PEND with cnt = 1.
    - SINGLE or MULTI: stay in HELD (no auto-repeat).
  - REL_PEND:
    - NONE: cnt+1. When cnt reaches DEBOUNCE → IDLE.
    - SINGLE or MULTI: → HELD.
- Accept actions (all in the same cycle):
  - key_valid = 1 and key_code = code.
  - # → arm pulse; digit_count cleared; partial code discarded.
  - * → unarm pulse; digit_count cleared; partial code discarded.
  - Digit → shift the code into the partial register.
    - If digit_count < 3: digit_count+1.
    - If digit_count = 3: keys = {partial[11:0], code}, openreq pulse, digit_count = 0.
- Timeout: with TIMEOUT_SCANS > 0, every full scan completed with digit_count ≠ 0 and no accept increments the timer. The timer clears on any accept. When it reaches TIMEOUT_SCANS, digit_count is cleared and the partial code is discarded. No pulse is issued.
- At most one of arm/unarm/openreq is high in any cycle. Each is high only together with key_valid.

## Timing
- Reset values:
  - col = 3'b001, dwell counter 0, FSM IDLE, all debounce and timeout counters 0.
  - key_valid/arm/unarm/openreq = 0.
  - key_code = 0, keys = 16'h0000, digit_count = 0.
- Reset mid-scan or mid-entry: reset has priority in the cycle it is asserted. Partial code lost; no pulse is emitted in that cycle.
- First col0 sample occurs SCAN_DIV cycles after reset deasserts. A full scan takes 3·SCAN_DIV cycles.
- Press latency: key_valid asserts 1 cycle after the col2 sample of the DEBOUNCE-th agreeing scan.
- Row changes within 2 cycles of a sample point may be seen in the next scan. This is acceptable.
- col changes only at dwell boundaries and is never zero or multi-hot.

## Test plan
- SCAN_DIV=4, DEBOUNCE=3. Hold r2c1 for 6 scans, then release for 4 scans → exactly one key_valid with key_code=4'h5, and the FSM returns to IDLE.
- Press 1,1,5,5, each held 4 scans and released 4 scans → single openreq pulse with keys=16'h1155. digit_count goes 1,2,3,0.
- Press r0c0 → arm pulse with key_code=4'hB, digit_count unchanged at 0. Enter 2 digits then r0c2 → unarm pulse, digit_count=0.
- Bounce: r3c2 present 2 scans, absent 1, present 3 → one key_valid (code 1). r1c0 and r2c2 held together for 5 scans → no key_valid.
- TIMEOUT_SCANS=10: enter 2 digits, then idle 10 scans → digit_count=0, no pulses. The next 4 digits 9,0,0,9 → keys=16'h9AA9.
- Assert rst during the 3rd digit's debounce → all outputs return to reset values, col=3'b001, no spurious pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: column drive, row sync/debounce, decode to lock commands.
// Latency: key_valid pulses 1 cycle after the col2 sample of the DEBOUNCE-th agreeing scan.
// Backpressure: none; command pulses are single-cycle and must be taken when issued.
module keypad_scanner #(
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE      = 3,
  parameter int TIMEOUT_SCANS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [2:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        arm,
  output logic        unarm,
  output logic        openreq,
  output logic [15:0] keys,
  output logic [2:0]  digit_count
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int TMO_W = (TIMEOUT_SCANS > 1) ? $clog2(TIMEOUT_SCANS + 1) : 1;

  localparam logic [3:0] CODE_HASH = 4'hB;
  localparam logic [3:0] CODE_STAR = 4'hC;

  typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, REL_PEND} state_t;

  // Synchronizer and scan sequencing
  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       col_q, col_d;
  logic [3:0]       samp0_q, samp1_q;
  logic             last_dwell, scan_end;

  // Debounce FSM
  state_t           state_q, state_d;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             accept;

  // Scan classification
  logic [2:0][3:0]  pat;
  logic [3:0]       n_hits;
  logic [1:0]       hit_r, hit_c;
  logic             is_none, is_single;
  logic [3:0]       code_w;

  // Code entry and outputs
  logic             key_valid_q, key_valid_d;
  logic             arm_q, arm_d, unarm_q, unarm_d, openreq_q, openreq_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [15:0]      keys_q, keys_d;
  logic [11:0]      part_q, part_d;
  logic [2:0]       dc_q, dc_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Keypad position to lock code; row 0 carries #, 0 and *.
  function automatic logic [3:0] key_to_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] v;
    if (r == 2'd0) begin
      case (c)
        2'd0:    v = CODE_HASH;
        2'd1:    v = 4'hA;
        default: v = CODE_STAR;
      endcase
    end else begin
      v = 4'd1 + 4'd3 * (4'd3 - {2'b00, r}) + (4'd2 - {2'b00, c});
    end
    return v;
  endfunction

  assign last_dwell = (div_q == DIV_W'(SCAN_DIV - 1));
  assign scan_end   = last_dwell & col_q[2];
  // col2 is evaluated straight from the synchronizer on its sample cycle
  assign pat        = {row_s2_q, samp1_q, samp0_q};

  // Dwell counter and one-hot column rotation
  always_comb begin
    div_d = div_q + DIV_W'(1);
    col_d = col_q;
    if (last_dwell) begin
      div_d = '0;
      col_d = {col_q[1:0], col_q[2]};
    end
  end

  // Classify the full 4x3 snapshot as NONE / SINGLE / MULTI
  always_comb begin
    n_hits = '0;
    hit_r  = '0;
    hit_c  = '0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pat[c][r]) begin
          n_hits = n_hits + 4'd1;
          hit_r  = 2'(r);
          hit_c  = 2'(c);
        end
      end
    end
    is_none   = (n_hits == 4'd0);
    is_single = (n_hits == 4'd1);
    code_w    = key_to_code(hit_r, hit_c);
  end

  // Debounce next-state: advances only on scan boundaries, no auto-repeat
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d = code_w;
            cnt_d  = DB_W'(1);
            if (DEBOUNCE == 1) begin
              accept  = 1'b1;
              state_d = HELD;
            end else begin
              state_d = PRESS_PEND;
            end
          end
        end
        PRESS_PEND: begin
          if (is_single && code_w == cand_q) begin
            cnt_d = cnt_q + DB_W'(1);
            if (cnt_q + DB_W'(1) == DB_W'(DEBOUNCE)) begin
              accept  = 1'b1;
              state_d = HELD;
            end
          end else if (is_single) begin
            cand_d = code_w;
            cnt_d  = DB_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (is_none) begin
            cnt_d   = DB_W'(1);
            state_d = (DEBOUNCE == 1) ? IDLE : REL_PEND;
          end
        end
        default: begin
          if (is_none) begin
            cnt_d = cnt_q + DB_W'(1);
            if (cnt_q + DB_W'(1) == DB_W'(DEBOUNCE)) state_d = IDLE;
          end else begin
            state_d = HELD;
          end
        end
      endcase
    end
  end

  // Accept actions, code assembly and partial-entry timeout
  always_comb begin
    key_valid_d = accept;
    arm_d       = 1'b0;
    unarm_d     = 1'b0;
    openreq_d   = 1'b0;
    key_code_d  = key_code_q;
    keys_d      = keys_q;
    part_d      = part_q;
    dc_d        = dc_q;
    tmo_d       = tmo_q;
    if (accept) begin
      key_code_d = code_w;
      tmo_d      = '0;
      if (code_w == CODE_HASH) begin
        arm_d  = 1'b1;
        dc_d   = '0;
        part_d = '0;
      end else if (code_w == CODE_STAR) begin
        unarm_d = 1'b1;
        dc_d    = '0;
        part_d  = '0;
      end else if (dc_q == 3'd3) begin
        keys_d    = {part_q, code_w};
        openreq_d = 1'b1;
        dc_d      = '0;
        part_d    = '0;
      end else begin
        part_d = {part_q[7:0], code_w};
        dc_d   = dc_q + 3'd1;
      end
    end else if (scan_end) begin
      if (TIMEOUT_SCANS != 0 && dc_q != 3'd0) begin
        if (tmo_q + TMO_W'(1) == TMO_W'(TIMEOUT_SCANS)) begin
          tmo_d  = '0;
          dc_d   = '0;
          part_d = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end else begin
        tmo_d = '0;
      end
    end
  end

  // State registers; reset wins over any accept in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q    <= '0;
      row_s2_q    <= '0;
      div_q       <= '0;
      col_q       <= 3'b001;
      samp0_q     <= '0;
      samp1_q     <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_valid_q <= 1'b0;
      arm_q       <= 1'b0;
      unarm_q     <= 1'b0;
      openreq_q   <= 1'b0;
      key_code_q  <= '0;
      keys_q      <= '0;
      part_q      <= '0;
      dc_q        <= '0;
      tmo_q       <= '0;
    end else begin
      row_s1_q    <= row;
      row_s2_q    <= row_s1_q;
      div_q       <= div_d;
      col_q       <= col_d;
      if (last_dwell && col_q[0]) samp0_q <= row_s2_q;
      if (last_dwell && col_q[1]) samp1_q <= row_s2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= key_valid_d;
      arm_q       <= arm_d;
      unarm_q     <= unarm_d;
      openreq_q   <= openreq_d;
      key_code_q  <= key_code_d;
      keys_q      <= keys_d;
      part_q      <= part_d;
      dc_q        <= dc_d;
      tmo_q       <= tmo_d;
    end
  end

  assign col         = col_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign arm         = arm_q;
  assign unarm       = unarm_q;
  assign openreq     = openreq_q;
  assign keys        = keys_q;
  assign digit_count = dc_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model driving rows from the column drive.
// Expected key events are queued by the stimulus and consumed by a key_valid monitor.
// Stimulus changes land on scan boundaries (multiples of 3*SCAN_DIV cycles after reset).
module tb_keypad_scanner;

  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int TO   = 10;
  localparam int SCAN = 3 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [2:0]  col;
  logic        key_valid, arm, unarm, openreq;
  logic [3:0]  key_code;
  logic [15:0] keys;
  logic [2:0]  digit_count;

  logic [11:0] pressed;  // bit r*3+c set while key (r,c) is held

  typedef struct packed {
    logic [3:0]  code;
    logic        arm;
    logic        unarm;
    logic        openreq;
    logic [15:0] keys;
    logic [2:0]  dc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB), .TIMEOUT_SCANS(TO)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_valid(key_valid), .key_code(key_code),
    .arm(arm), .unarm(unarm), .openreq(openreq),
    .keys(keys), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  // Passive matrix: a held key connects its column line to its row line
  always_comb begin
    row = 4'b0000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && col[c]) row[r] = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void expect_key(input logic [3:0] code, input logic a, input logic u,
                                     input logic o, input logic [15:0] k, input logic [2:0] dc);
    exp_t e;
    e.code = code; e.arm = a; e.unarm = u; e.openreq = o; e.keys = k; e.dc = dc;
    exp_q.push_back(e);
  endfunction

  // Monitor: every key_valid must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (key_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_key: got code 0x%0h, expected no key event", key_code);
      end else begin
        e = exp_q.pop_front();
        chk("key_code", 32'(key_code), 32'(e.code));
        chk("arm", 32'(arm), 32'(e.arm));
        chk("unarm", 32'(unarm), 32'(e.unarm));
        chk("openreq", 32'(openreq), 32'(e.openreq));
        chk("digit_count_at_key", 32'(digit_count), 32'(e.dc));
        if (e.openreq) chk("keys_at_openreq", 32'(keys), 32'(e.keys));
      end
    end else if (arm || unarm || openreq) begin
      checks++;
      failures++;
      $display("FAIL pulse_without_valid: got arm/unarm/openreq=%b%b%b, expected 000", arm, unarm, openreq);
    end
  end

  task automatic wait_scans(input int n);
    repeat (n * SCAN) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    pressed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input int r, input int c, input int hold, input int rel);
    pressed = '0;
    pressed[r*3+c] = 1'b1;
    wait_scans(hold);
    pressed = '0;
    wait_scans(rel);
  endtask

  initial begin
    rst     = 1'b1;
    pressed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_col", 32'(col), 32'h1);
    chk("reset_key_valid", 32'(key_valid), 32'h0);
    chk("reset_key_code", 32'(key_code), 32'h0);
    chk("reset_keys", 32'(keys), 32'h0);
    chk("reset_digit_count", 32'(digit_count), 32'h0);
    chk("reset_pulses", 32'({arm, unarm, openreq}), 32'h0);
    rst = 1'b0;

    // Single long press of r2c1 (digit 5): exactly one event
    expect_key(4'h5, 0, 0, 0, 16'h0, 3'd1);
    press(2, 1, 6, 4);
    chk("long_press_dc", 32'(digit_count), 32'd1);

    // Four digits 1,1,5,5 form an open request
    do_reset();
    expect_key(4'h1, 0, 0, 0, 16'h0, 3'd1);
    expect_key(4'h1, 0, 0, 0, 16'h0, 3'd2);
    expect_key(4'h5, 0, 0, 0, 16'h0, 3'd3);
    expect_key(4'h5, 0, 0, 1, 16'h1155, 3'd0);
    press(3, 2, 4, 4);
    chk("dc_after_1st", 32'(digit_count), 32'd1);
    press(3, 2, 4, 4);
    chk("dc_after_2nd", 32'(digit_count), 32'd2);
    press(2, 1, 4, 4);
    chk("dc_after_3rd", 32'(digit_count), 32'd3);
    press(2, 1, 4, 4);
    chk("dc_after_4th", 32'(digit_count), 32'd0);
    chk("keys_1155", 32'(keys), 32'h1155);

    // # arms without touching digit_count; * discards a partial entry
    expect_key(4'hB, 1, 0, 0, 16'h0, 3'd0);
    press(0, 0, 4, 4);
    chk("dc_after_arm", 32'(digit_count), 32'd0);
    expect_key(4'h2, 0, 0, 0, 16'h0, 3'd1);
    expect_key(4'h3, 0, 0, 0, 16'h0, 3'd2);
    expect_key(4'hC, 0, 1, 0, 16'h0, 3'd0);
    press(3, 1, 4, 4);
    press(3, 0, 4, 4);
    press(0, 2, 4, 4);
    chk("dc_after_unarm", 32'(digit_count), 32'd0);
    chk("keys_held_after_unarm", 32'(keys), 32'h1155);

    // Two keys at once never produce an event; a bounced press yields one
    do_reset();
    pressed = '0;
    pressed[1*3+0] = 1'b1;
    pressed[2*3+2] = 1'b1;
    wait_scans(5);
    pressed = '0;
    wait_scans(4);
    chk("multi_no_digit", 32'(digit_count), 32'd0);
    expect_key(4'h1, 0, 0, 0, 16'h0, 3'd1);
    pressed = '0;
    pressed[3*3+2] = 1'b1;
    wait_scans(2);
    pressed = '0;
    wait_scans(1);
    pressed[3*3+2] = 1'b1;
    wait_scans(3);
    pressed = '0;
    wait_scans(4);
    chk("bounce_dc", 32'(digit_count), 32'd1);

    // Partial entry expires after TO idle scans, then a fresh code works
    do_reset();
    expect_key(4'h2, 0, 0, 0, 16'h0, 3'd1);
    expect_key(4'h3, 0, 0, 0, 16'h0, 3'd2);
    press(3, 1, 4, 4);
    press(3, 0, 4, 4);
    chk("dc_partial", 32'(digit_count), 32'd2);
    wait_scans(4);
    chk("dc_before_timeout", 32'(digit_count), 32'd2);
    wait_scans(1);
    chk("dc_after_timeout", 32'(digit_count), 32'd0);
    expect_key(4'h9, 0, 0, 0, 16'h0, 3'd1);
    expect_key(4'hA, 0, 0, 0, 16'h0, 3'd2);
    expect_key(4'hA, 0, 0, 0, 16'h0, 3'd3);
    expect_key(4'h9, 0, 0, 1, 16'h9AA9, 3'd0);
    press(1, 0, 4, 4);
    press(0, 1, 4, 4);
    press(0, 1, 4, 4);
    press(1, 0, 4, 4);
    chk("keys_9AA9", 32'(keys), 32'h9AA9);

    // Reset in the middle of the third digit's debounce
    do_reset();
    expect_key(4'h1, 0, 0, 0, 16'h0, 3'd1);
    expect_key(4'h2, 0, 0, 0, 16'h0, 3'd2);
    press(3, 2, 4, 4);
    press(3, 1, 4, 4);
    pressed = '0;
    pressed[3*3+0] = 1'b1;
    wait_scans(2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_col", 32'(col), 32'h1);
    chk("midrst_key_valid", 32'(key_valid), 32'h0);
    chk("midrst_key_code", 32'(key_code), 32'h0);
    chk("midrst_dc", 32'(digit_count), 32'h0);
    chk("midrst_keys", 32'(keys), 32'h0);
    pressed = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_scans(6);
    chk("post_rst_dc", 32'(digit_count), 32'h0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
